// File: rtl/sap_pkg.sv
// Shared types and default widths for the SAP memory arbiter.
package sap_pkg;

   localparam int SAP_ADDR_W = 4;
   localparam int SAP_DATA_W = 8;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      TURN = 2'd1,
      RUN  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the shared program memory between the external loader and the CPU.
// Define MEM_ARB_AUTO_ADDR_EN to write loader beats to an internal incrementing pointer.
module mem_arbiter
   import sap_pkg::*;
#(
   parameter int ADDR_W = SAP_ADDR_W,
   parameter int DATA_W = SAP_DATA_W
) (
   input  logic              CLK,
   input  logic              CLR_bar,
   input  logic              run_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              CE_bar,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] cpu_data,
   output logic              cpu_data_en,
   output logic              cpu_hold,
   output logic [ADDR_W:0]   load_cnt
);

   localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   arb_state_t        state_r;
   logic [ADDR_W:0]   load_cnt_r;
   logic              beat_s;
   logic [ADDR_W-1:0] waddr_s;

`ifdef MEM_ARB_AUTO_ADDR_EN
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   logic [ADDR_W-1:0] ptr_r;
   assign waddr_s = ptr_r;
`else
   assign waddr_s = ld_addr;
`endif

   // Reset gates the beat so an aborted cycle never reaches the memory.
   assign beat_s   = CLR_bar && (state_r == LOAD) && ld_valid;
   assign load_cnt = load_cnt_r;

   // Ownership FSM plus the inline beat counter (and pointer when enabled).
   always_ff @(posedge CLK) begin
      if (!CLR_bar) begin
         state_r    <= LOAD;
         load_cnt_r <= {(ADDR_W+1){1'b0}};
`ifdef MEM_ARB_AUTO_ADDR_EN
         ptr_r      <= {ADDR_W{1'b0}};
`endif
      end else begin
         case (state_r)
            LOAD: begin
               if (beat_s) begin
                  if (load_cnt_r != CNT_MAX) begin
                     load_cnt_r <= load_cnt_r + CNT_ONE;
                  end
`ifdef MEM_ARB_AUTO_ADDR_EN
                  ptr_r <= ptr_r + PTR_ONE;
`endif
               end
               if (run_req) begin
                  state_r <= TURN;
               end
            end
            TURN: begin
               state_r <= RUN;
            end
            RUN: begin
               // A CPU read in progress keeps ownership until CE_bar releases.
               if (!run_req && CE_bar) begin
                  state_r    <= LOAD;
                  load_cnt_r <= {(ADDR_W+1){1'b0}};
`ifdef MEM_ARB_AUTO_ADDR_EN
                  ptr_r      <= {ADDR_W{1'b0}};
`endif
               end
            end
            default: begin
               state_r <= LOAD;
            end
         endcase
      end
   end

   // Memory-port and CPU-side outputs decoded from the owner and live inputs.
   always_comb begin
      ld_ready    = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = cpu_addr;
      mem_wdata   = {DATA_W{1'b0}};
      cpu_data    = {DATA_W{1'b0}};
      cpu_data_en = 1'b0;
      cpu_hold    = 1'b1;
      if (CLR_bar) begin
         case (state_r)
            LOAD: begin
               ld_ready  = 1'b1;
               mem_we    = beat_s;
               mem_addr  = waddr_s;
               mem_wdata = ld_data;
            end
            TURN: begin
               cpu_hold = 1'b1;
            end
            RUN: begin
               cpu_hold = 1'b0;
               if (!CE_bar) begin
                  cpu_data    = mem_rdata;
                  cpu_data_en = 1'b1;
               end else begin
                  cpu_data    = {DATA_W{1'b0}};
                  cpu_data_en = 1'b0;
               end
            end
            default: begin
               cpu_hold = 1'b1;
            end
         endcase
      end else begin
         ld_ready = 1'b0;
         cpu_hold = 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a behavioural ownership model.
module tb_mem_arbiter;

   logic       CLK = 1'b0;
   logic       CLR_bar, run_req, CE_bar, ld_valid;
   logic [3:0] cpu_addr, ld_addr;
   logic [7:0] ld_data;
   logic       ld_ready, mem_we, cpu_data_en, cpu_hold;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata, cpu_data;
   logic [4:0] load_cnt;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
      .CLK(CLK), .CLR_bar(CLR_bar), .run_req(run_req), .cpu_addr(cpu_addr),
      .CE_bar(CE_bar), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ready(ld_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .cpu_data(cpu_data), .cpu_data_en(cpu_data_en),
      .cpu_hold(cpu_hold), .load_cnt(load_cnt)
   );

   always #5 CLK = ~CLK;

   // Memory array attached to the DUT's memory port
   logic [7:0] bmem [16];
   assign mem_rdata = bmem[mem_addr];
   always @(negedge CLK) if (mem_we === 1'b1) bmem[mem_addr] = mem_wdata;

   // Behavioural model: owner, beat count, load pointer, expected memory contents
   localparam int M_LOAD = 0, M_TURN = 1, M_RUN = 2;
   int         m_mode  = M_LOAD;
   int         m_cnt   = 0;
   int         m_ptr   = 0;
   bit         m_valid = 1'b0;
   logic [7:0] m_mem [16];

   function automatic logic [3:0] exp_waddr();
`ifdef MEM_ARB_AUTO_ADDR_EN
      return m_ptr[3:0];
`else
      return ld_addr;
`endif
   endfunction

   always @(posedge CLK) begin
      if (CLR_bar === 1'b0) begin
         m_mode = M_LOAD; m_cnt = 0; m_ptr = 0; m_valid = 1'b1;
      end else if (m_mode == M_LOAD) begin
         if (ld_valid) begin
            m_mem[exp_waddr()] = ld_data;
            m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
            m_ptr = (m_ptr + 1) % 16;
         end
         if (run_req) m_mode = M_TURN;
      end else if (m_mode == M_TURN) begin
         m_mode = M_RUN;
      end else if (!run_req && CE_bar) begin
         m_mode = M_LOAD; m_cnt = 0; m_ptr = 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of the DUT against the model
   always @(negedge CLK) begin
      if (m_valid) begin
         logic       rd;
         logic       en_e;
         rd   = CLR_bar && (m_mode == M_RUN);
         en_e = rd && !CE_bar;
         chk("ld_ready", ld_ready, CLR_bar && (m_mode == M_LOAD));
         chk("mem_we", mem_we, CLR_bar && (m_mode == M_LOAD) && ld_valid);
         chk("cpu_hold", cpu_hold, !rd);
         chk("cpu_data_en", cpu_data_en, en_e);
         chk("cpu_data", cpu_data, en_e ? m_mem[cpu_addr] : 8'h00);
         chk("load_cnt", load_cnt, m_cnt);
         chk("we_and_en", mem_we && cpu_data_en, 1'b0);
         if (CLR_bar && (m_mode == M_LOAD) && ld_valid) begin
            chk("wr_addr", mem_addr, exp_waddr());
            chk("wr_data", mem_wdata, ld_data);
         end
         if (rd) chk("run_addr", mem_addr, cpu_addr);
      end
   end

   task automatic drive(input logic rst, input logic run, input logic ce, input logic v,
                        input logic [3:0] la, input logic [7:0] ld, input logic [3:0] ca);
      @(posedge CLK);
      #1;
      CLR_bar = rst; run_req = run; CE_bar = ce; ld_valid = v;
      ld_addr = la; ld_data = ld; cpu_addr = ca;
      @(negedge CLK);
      #1;
   endtask

`ifdef MEM_ARB_AUTO_ADDR_EN
   localparam logic [3:0] A4 = 4'd3;
`else
   localparam logic [3:0] A4 = 4'd4;
`endif

   initial begin
      logic [7:0] d3 [3];
      d3[0] = 8'h09; d3[1] = 8'h1A; d3[2] = 8'hE0;
      for (int i = 0; i < 16; i++) begin bmem[i] = 8'h00; m_mem[i] = 8'h00; end
      CLR_bar = 1'b0; run_req = 1'b0; CE_bar = 1'b1; ld_valid = 1'b1;
      ld_addr = 4'h0; ld_data = 8'h55; cpu_addr = 4'h0;

      // Reset with a beat offered: nothing may be written
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 8'h55, 4'h0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 8'h55, 4'h0);
      chk("pin_rst_ready", ld_ready, 1'b0);
      chk("pin_rst_we", mem_we, 1'b0);
      chk("pin_rst_hold", cpu_hold, 1'b1);
      chk("pin_rst_cnt", load_cnt, 5'd0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h0);
      chk("pin_load_ready", ld_ready, 1'b1);

      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b1, 4'(i), d3[i], 4'h0);
         chk("pin_beat_we", mem_we, 1'b1);
         chk("pin_beat_addr", mem_addr, 4'(i));
         chk("pin_beat_data", mem_wdata, d3[i]);
      end
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h0);
      chk("pin_cnt3", load_cnt, 5'd3);

      // Beat coincident with run_req, then TURN, then RUN
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h4, 8'h2C, 4'h0);
      chk("pin_lastbeat_addr", mem_addr, A4);
      chk("pin_lastbeat_we", mem_we, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 8'h77, 4'h0);
      chk("pin_turn_hold", cpu_hold, 1'b1);
      chk("pin_turn_we", mem_we, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, A4);
      chk("pin_run_hold", cpu_hold, 1'b0);
      chk("pin_run_data", cpu_data, 8'h2C);
      chk("pin_run_en", cpu_data_en, 1'b1);
      chk("pin_run_ready", ld_ready, 1'b0);

      // run_req drops mid-read: keep RUN until CE_bar releases
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, A4);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, A4);
      chk("pin_hold_run", cpu_hold, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, A4);
      chk("pin_ce_off_en", cpu_data_en, 1'b0);
      chk("pin_ce_off_data", cpu_data, 8'h00);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, A4);
      chk("pin_back_load", cpu_hold, 1'b1);
      chk("pin_back_cnt", load_cnt, 5'd0);

      // 17 beats: counter saturates at 16
      for (int i = 0; i < 17; i++)
         drive(1'b1, 1'b0, 1'b1, 1'b1, 4'(i), 8'(8'hA0 + i), 4'h0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h0);
      chk("pin_cnt_sat", load_cnt, 5'd16);

      // Reset pulsed during RUN
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 4'h0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 4'h0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 4'h3);
      chk("pin_run2_hold", cpu_hold, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 8'hBB, 4'h3);
      chk("pin_rstrun_en", cpu_data_en, 1'b0);
      chk("pin_rstrun_we", mem_we, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h3);
      chk("pin_after_rst_hold", cpu_hold, 1'b1);
      chk("pin_after_rst_cnt", load_cnt, 5'd0);

      // Randomized traffic with sticky run_req
      for (int i = 0; i < 3000; i++) begin
         logic run_v;
         run_v = ($urandom_range(0, 9) < 2) ? ~run_req : run_req;
         drive(($urandom_range(0, 79) != 0), run_v, 1'($urandom), 1'($urandom),
               4'($urandom), 8'($urandom), 4'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
